// File: rtl/exec_issue_fwd.sv
// Execute-stage issue control with an in-flight result tracker.
// Resolves RAW hazards against DEPTH post-execute slots by forwarding or stalling.
module exec_issue_fwd #(
    parameter int unsigned RW        = 16,
    parameter int unsigned REGNO     = 8,
    parameter int unsigned REGNO_LOG = 3,
    parameter int unsigned OPERANDS  = 2,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned LATE_SLOT = 1,
    parameter int unsigned FORWARD   = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_submit,
    output logic                        o_ready,
    input  logic                        i_flush,
    input  logic                        i_irq,
    input  logic                        i_next_ready,
    input  logic [OPERANDS*REGNO_LOG-1:0] i_src_sel,
    input  logic [OPERANDS-1:0]         i_src_used,
    input  logic [OPERANDS*RW-1:0]      i_rf_data,
    input  logic [REGNO-1:0]            i_dst_ie,
    input  logic [RW-1:0]               i_result,
    input  logic                        i_result_late,
    input  logic                        i_late_valid,
    input  logic [RW-1:0]               i_late_data,
    output logic                        o_exec_submit,
    output logic [OPERANDS*RW-1:0]      o_operand,
    output logic [OPERANDS-1:0]         o_fwd_hit,
    output logic                        o_stall
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LATE_IDX = LATE_SLOT[IDX_W-1:0];
    localparam logic FWD_EN = (FORWARD != 0);

    // In-flight slots; index 0 is the youngest entry.
    logic             slot_valid_q [DEPTH];
    logic             slot_valid_d [DEPTH];
    logic             slot_rdy_q   [DEPTH];
    logic             slot_rdy_d   [DEPTH];
    logic [REGNO-1:0] slot_dst_q   [DEPTH];
    logic [REGNO-1:0] slot_dst_d   [DEPTH];
    logic [RW-1:0]    slot_data_q  [DEPTH];
    logic [RW-1:0]    slot_data_d  [DEPTH];

    logic             fill_rdy  [DEPTH];
    logic [RW-1:0]    fill_data [DEPTH];

    logic hold_valid_q;
    logic hold_valid_d;

    logic invalidate;
    logic in_valid;
    logic instr_valid;
    logic exec_submit;
    logic late_fill;
    logic [OPERANDS-1:0] hazard;
    logic [OPERANDS-1:0] fwd_hit;

    assign invalidate  = i_flush | i_irq;
    assign in_valid    = i_submit & ~invalidate;
    assign instr_valid = in_valid | (hold_valid_q & ~i_submit & ~invalidate);

    // Operand resolution: youngest matching slot is the producer.
    for (genvar j = 0; j < OPERANDS; j++) begin : g_opnd
        logic [REGNO_LOG-1:0] sel;
        logic                 found;
        logic                 prod_rdy;
        logic [RW-1:0]        prod_data;

        assign sel = i_src_sel[j*REGNO_LOG +: REGNO_LOG];

        always_comb begin
            found     = 1'b0;
            prod_rdy  = 1'b0;
            prod_data = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slot_valid_q[k] && slot_dst_q[k][sel]) begin
                    found     = 1'b1;
                    prod_rdy  = slot_rdy_q[k];
                    prod_data = slot_data_q[k];
                end
            end
        end

        assign hazard[j]  = i_src_used[j] & found & ~(prod_rdy & FWD_EN);
        assign fwd_hit[j] = i_src_used[j] & found & prod_rdy & FWD_EN;
        assign o_operand[j*RW +: RW] = fwd_hit[j] ? prod_data : i_rf_data[j*RW +: RW];
    end

    assign o_stall       = instr_valid & (|hazard);
    assign exec_submit   = i_next_ready & instr_valid & ~o_stall;
    assign o_exec_submit = exec_submit;
    assign o_ready       = exec_submit | ~instr_valid;
    assign o_fwd_hit     = fwd_hit;

    // Late data is only visible through registered state, never bypassed.
    assign late_fill = i_late_valid & slot_valid_q[LATE_IDX] & ~slot_rdy_q[LATE_IDX];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            fill_rdy[k]  = slot_rdy_q[k];
            fill_data[k] = slot_data_q[k];
        end
        if (late_fill) begin
            fill_rdy[LATE_IDX]  = 1'b1;
            fill_data[LATE_IDX] = i_late_data;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_valid_d[k] = slot_valid_q[k];
            slot_dst_d[k]   = slot_dst_q[k];
            slot_rdy_d[k]   = fill_rdy[k];
            slot_data_d[k]  = fill_data[k];
        end
        if (i_next_ready) begin
            // Oldest entry drops off the end; the register file takes it this edge.
            for (int k = 1; k < DEPTH; k++) begin
                slot_valid_d[k] = slot_valid_q[k-1];
                slot_dst_d[k]   = slot_dst_q[k-1];
                slot_rdy_d[k]   = fill_rdy[k-1];
                slot_data_d[k]  = fill_data[k-1];
            end
            slot_valid_d[0] = exec_submit;
            slot_dst_d[0]   = exec_submit ? i_dst_ie : '0;
            slot_data_d[0]  = exec_submit ? i_result : '0;
            slot_rdy_d[0]   = exec_submit & ~i_result_late;
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        if (invalidate || exec_submit) begin
            hold_valid_d = 1'b0;
        end else if (in_valid) begin
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_valid_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_valid_q[k] <= 1'b0;
                slot_rdy_q[k]   <= 1'b0;
                slot_dst_q[k]   <= '0;
                slot_data_q[k]  <= '0;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            for (int k = 0; k < DEPTH; k++) begin
                slot_valid_q[k] <= slot_valid_d[k];
                slot_rdy_q[k]   <= slot_rdy_d[k];
                slot_dst_q[k]   <= slot_dst_d[k];
                slot_data_q[k]  <= slot_data_d[k];
            end
        end
    end

endmodule

// File: tb/tb_exec_issue_fwd.sv
// Bench for exec_issue_fwd: a forwarding and a stall-only instance share stimulus,
// each checked against its own pipeline/register-file model.
module tb_exec_issue_fwd;

    localparam int RW = 16, REGNO = 8, RL = 3, OPS = 2, DEPTH = 2, LATE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, submit, flush, irq, nr, res_late, late_valid;
    logic [OPS*RL-1:0] src_sel;
    logic [OPS-1:0]    src_used;
    logic [REGNO-1:0]  dst_ie;
    logic [RW-1:0]     result, late_data;
    logic [OPS*RW-1:0] rf_data [2];

    logic              ready_o [2];
    logic              es_o    [2];
    logic              stall_o [2];
    logic [OPS*RW-1:0] op_o    [2];
    logic [OPS-1:0]    hit_o   [2];

    exec_issue_fwd #(.RW(RW), .REGNO(REGNO), .REGNO_LOG(RL), .OPERANDS(OPS), .DEPTH(DEPTH),
                     .LATE_SLOT(LATE), .FORWARD(1)) u_fwd (
        .i_clk(clk), .i_rst(rst), .i_submit(submit), .o_ready(ready_o[0]), .i_flush(flush),
        .i_irq(irq), .i_next_ready(nr), .i_src_sel(src_sel), .i_src_used(src_used),
        .i_rf_data(rf_data[0]), .i_dst_ie(dst_ie), .i_result(result),
        .i_result_late(res_late), .i_late_valid(late_valid), .i_late_data(late_data),
        .o_exec_submit(es_o[0]), .o_operand(op_o[0]), .o_fwd_hit(hit_o[0]),
        .o_stall(stall_o[0])
    );

    exec_issue_fwd #(.RW(RW), .REGNO(REGNO), .REGNO_LOG(RL), .OPERANDS(OPS), .DEPTH(DEPTH),
                     .LATE_SLOT(LATE), .FORWARD(0)) u_nofwd (
        .i_clk(clk), .i_rst(rst), .i_submit(submit), .o_ready(ready_o[1]), .i_flush(flush),
        .i_irq(irq), .i_next_ready(nr), .i_src_sel(src_sel), .i_src_used(src_used),
        .i_rf_data(rf_data[1]), .i_dst_ie(dst_ie), .i_result(result),
        .i_result_late(res_late), .i_late_valid(late_valid), .i_late_data(late_data),
        .o_exec_submit(es_o[1]), .o_operand(op_o[1]), .o_fwd_hit(hit_o[1]),
        .o_stall(stall_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: in-flight results as a short list plus an architectural register file.
    bit            mv   [2][DEPTH];
    int            md   [2][DEPTH];
    logic [RW-1:0] mdat [2][DEPTH];
    bit            mrdy [2][DEPTH];
    bit            mhold[2];
    logic [RW-1:0] rf   [2][REGNO];

    bit            e_stall [2];
    bit            e_es    [2];
    bit            e_ready [2];
    bit            e_haz   [2][OPS];
    bit            e_hit   [2][OPS];
    logic [RW-1:0] e_op    [2][OPS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int dst_num(input logic [REGNO-1:0] oh);
        for (int i = 0; i < REGNO; i++) if (oh[i]) return i;
        return -1;
    endfunction

    function automatic int sel_of(input int j);
        logic [OPS*RL-1:0] s;
        s = src_sel;
        return int'(s[j*RL +: RL]);
    endfunction

    task automatic compute(input int m, input bit fwd);
        bit inval, iv, instr, any;
        int prod;
        inval = flush | irq;
        iv    = submit & !inval;
        instr = iv | (mhold[m] & !submit & !inval);
        any   = 0;
        for (int j = 0; j < OPS; j++) begin
            e_op[m][j]  = rf[m][sel_of(j)];
            e_hit[m][j] = 0;
            e_haz[m][j] = 0;
            if (src_used[j]) begin
                prod = -1;
                for (int k = 0; k < DEPTH && prod < 0; k++)
                    if (mv[m][k] && md[m][k] == sel_of(j)) prod = k;
                if (prod >= 0) begin
                    if (mrdy[m][prod] && fwd) begin
                        e_op[m][j]  = mdat[m][prod];
                        e_hit[m][j] = 1;
                    end else begin
                        e_haz[m][j] = 1;
                    end
                end
                any |= e_haz[m][j];
            end
        end
        e_stall[m] = instr & any;
        e_es[m]    = nr & instr & !e_stall[m];
        e_ready[m] = e_es[m] | !instr;
    endtask

    task automatic check_model(input int m);
        check_eq($sformatf("i%0d_stall", m), stall_o[m], e_stall[m]);
        check_eq($sformatf("i%0d_exec_submit", m), es_o[m], e_es[m]);
        check_eq($sformatf("i%0d_ready", m), ready_o[m], e_ready[m]);
        for (int j = 0; j < OPS; j++) begin
            check_eq($sformatf("i%0d_hit%0d", m, j), hit_o[m][j], e_hit[m][j]);
            if (!e_haz[m][j])
                check_eq($sformatf("i%0d_op%0d", m, j), op_o[m][j*RW +: RW], e_op[m][j]);
        end
    endtask

    task automatic update(input int m);
        int d;
        if (rst) begin
            mhold[m] = 0;
            for (int k = 0; k < DEPTH; k++) begin
                mv[m][k] = 0; mrdy[m][k] = 0; mdat[m][k] = '0; md[m][k] = -1;
            end
            return;
        end
        if (late_valid && mv[m][LATE] && !mrdy[m][LATE]) begin
            mdat[m][LATE] = late_data;
            mrdy[m][LATE] = 1;
        end
        if (nr) begin
            d = md[m][DEPTH-1];
            if (mv[m][DEPTH-1] && d >= 0) rf[m][d] = mdat[m][DEPTH-1];
            for (int k = DEPTH - 1; k > 0; k--) begin
                mv[m][k] = mv[m][k-1]; md[m][k] = md[m][k-1];
                mdat[m][k] = mdat[m][k-1]; mrdy[m][k] = mrdy[m][k-1];
            end
            mv[m][0]   = e_es[m];
            md[m][0]   = dst_num(dst_ie);
            mdat[m][0] = result;
            mrdy[m][0] = e_es[m] & !res_late;
        end
        if (flush || irq || e_es[m]) mhold[m] = 0;
        else if (submit) mhold[m] = 1;
    endtask

    task automatic settle();
        for (int m = 0; m < 2; m++)
            for (int j = 0; j < OPS; j++)
                rf_data[m][j*RW +: RW] = rf[m][sel_of(j)];
        @(negedge clk);
        compute(0, 1'b1);
        compute(1, 1'b0);
        check_model(0);
        check_model(1);
    endtask

    task automatic tick();
        @(posedge clk);
        update(0);
        update(1);
        #1;
    endtask

    task automatic idle();
        rst = 0; submit = 0; flush = 0; irq = 0; nr = 1; src_sel = '0; src_used = '0;
        dst_ie = '0; result = '0; res_late = 0; late_valid = 0; late_data = '0;
    endtask

    task automatic issue(input int dst, input logic [RW-1:0] res, input bit late,
                         input int s0, input int s1, input logic [OPS-1:0] used);
        submit   = 1;
        dst_ie   = (dst < 0) ? '0 : REGNO'(1) << dst;
        result   = res;
        res_late = late;
        src_sel  = {RL'(s1), RL'(s0)};
        src_used = used;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        settle();
        tick();
        rst = 0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mhold[m] = 0;
            for (int r = 0; r < REGNO; r++) rf[m][r] = RW'(r * 16'h0111);
            for (int k = 0; k < DEPTH; k++) begin
                mv[m][k] = 0; mrdy[m][k] = 0; mdat[m][k] = '0; md[m][k] = -1;
            end
        end
        idle();
        rst = 1;
        for (int m = 0; m < 2; m++) rf_data[m] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        settle();
        check_eq("rst_ready", ready_o[0], 1);
        check_eq("rst_stall", stall_o[0], 0);
        check_eq("rst_exec_submit", es_o[0], 0);
        check_eq("rst_hit", hit_o[0], 0);
        tick();

        // Back-to-back forward; the stall-only copy waits DEPTH advancing cycles
        do_reset();
        issue(1, 16'd8, 0, 0, 0, 2'b00);
        settle();
        check_eq("fwd_prod_submit", es_o[0], 1);
        tick();
        issue(2, 16'd9, 0, 1, 0, 2'b01);
        settle();
        check_eq("fwd_op0", op_o[0][RW-1:0], 16'd8);
        check_eq("fwd_hit0", hit_o[0][0], 1);
        check_eq("fwd_stall", stall_o[0], 0);
        check_eq("nofwd_stall_c1", stall_o[1], 1);
        tick();
        settle();
        check_eq("nofwd_stall_c2", stall_o[1], 1);
        tick();
        settle();
        check_eq("nofwd_stall_c3", stall_o[1], 0);
        check_eq("nofwd_op0", op_o[1][RW-1:0], 16'd8);
        check_eq("nofwd_hit0", hit_o[1][0], 0);
        tick();

        // Load-use
        do_reset();
        issue(3, 16'hdead, 1, 0, 0, 2'b00);
        settle();
        tick();
        issue(5, 16'd1, 0, 3, 0, 2'b01);
        settle();
        check_eq("lu_stall_c1", stall_o[0], 1);
        tick();
        submit = 0; nr = 0; late_valid = 1; late_data = 16'h1234;
        settle();
        check_eq("lu_stall_c2", stall_o[0], 1);
        tick();
        late_valid = 0; nr = 1;
        settle();
        check_eq("lu_stall_c3", stall_o[0], 0);
        check_eq("lu_submit", es_o[0], 1);
        check_eq("lu_op0", op_o[0][RW-1:0], 16'h1234);
        check_eq("lu_hit0", hit_o[0][0], 1);
        tick();

        // Youngest producer wins
        do_reset();
        issue(4, 16'haaaa, 0, 0, 0, 2'b00);
        settle(); tick();
        issue(4, 16'h5555, 0, 0, 0, 2'b00);
        settle(); tick();
        issue(-1, 16'd0, 0, 0, 4, 2'b10);
        settle();
        check_eq("young_op1", op_o[0][RW +: RW], 16'h5555);
        check_eq("young_hit1", hit_o[0][1], 1);
        tick();

        // Flush while a consumer is held
        do_reset();
        issue(3, 16'hbeef, 1, 0, 0, 2'b00);
        settle(); tick();
        issue(6, 16'd2, 0, 3, 0, 2'b01);
        settle();
        check_eq("fl_stall", stall_o[0], 1);
        tick();
        submit = 0; flush = 1;
        settle();
        check_eq("fl_ready", ready_o[0], 1);
        check_eq("fl_submit", es_o[0], 0);
        tick();
        flush = 0;
        settle();
        check_eq("fl_after_ready", ready_o[0], 1);
        check_eq("fl_after_stall", stall_o[0], 0);
        tick();

        // Reset mid-operation
        do_reset();
        issue(6, 16'h0abc, 0, 0, 0, 2'b00);
        settle(); tick();
        issue(7, 16'h0def, 0, 0, 0, 2'b00);
        settle(); tick();
        idle(); nr = 0; rst = 1;
        settle(); tick();
        rst = 0;
        issue(-1, 16'd0, 0, 6, 7, 2'b11);
        settle();
        check_eq("rm_hit", hit_o[0], 0);
        check_eq("rm_stall", stall_o[0], 0);
        check_eq("rm_op0", op_o[0][RW-1:0], rf[0][6]);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst        = ($urandom % 200) == 0;
            submit     = ($urandom % 4) != 0;
            flush      = ($urandom % 16) == 0;
            irq        = ($urandom % 32) == 0;
            nr         = ($urandom % 4) != 0;
            src_sel    = OPS*RL'($urandom);
            src_used   = OPS'($urandom);
            r          = int'($urandom % 9);
            dst_ie     = (r == 8) ? '0 : REGNO'(1) << r;
            result     = RW'($urandom);
            res_late   = ($urandom % 4) == 0;
            late_valid = ($urandom % 3) == 0;
            late_data  = RW'($urandom);
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
